// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - byte-serial instruction prefetcher feeding a small FIFO
module instr_prefetch_queue #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    INSTR_WIDTH = 64,
    parameter int                    DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_PC     = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  flush_pc,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_rvalid,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   halted
);

    localparam int BYTES = INSTR_WIDTH / DATA_WIDTH;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic                   r_mem_req;
    logic                   r_halted;
    logic [IDXW-1:0]        r_byte_idx;
    logic [INSTR_WIDTH-1:0] r_asm;

    logic [INSTR_WIDTH-1:0] r_q_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_q_pc    [DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic [INSTR_WIDTH-1:0] w_asm_next;
    logic                   w_last;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_instr_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_last        = (r_byte_idx == IDXW'(BYTES - 1));
    assign w_instr_valid = (r_count != '0);
    // Flush wins over both queue ports: the queue is emptied that edge anyway.
    assign w_push        = !flush && (r_state == WAIT) && mem_rvalid && w_last;
    assign w_pop         = !flush && w_instr_valid && instr_ready;

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = w_instr_valid;
    assign instr_o     = r_q_instr[r_rptr];
    assign pc_o        = r_q_pc[r_rptr];
    assign halted      = r_halted;

    // Merge the returning byte into its little-endian lane of the assembly word.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < BYTES; k++) begin
            if (k == int'(r_byte_idx)) begin
                w_asm_next[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            end
        end
    end

    // Fetch FSM: one read in flight at a time, mem_req/mem_addr registered on entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= BASE_PC;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_halted   <= 1'b0;
            r_byte_idx <= '0;
            r_asm      <= '0;
        end else begin
            r_mem_req <= 1'b0;
            if (flush) begin
                r_fetch_pc <= flush_pc;
                r_byte_idx <= '0;
                r_asm      <= '0;
                r_halted   <= 1'b0;
                case (r_state)
                    // The request is on the bus this cycle; its data is still to come.
                    REQ:         r_state <= DRAIN;
                    // A response landing on the flush edge closes the read; nothing left to drain.
                    WAIT, DRAIN: r_state <= mem_rvalid ? IDLE : DRAIN;
                    default:     r_state <= IDLE;
                endcase
            end else begin
                case (r_state)
                    IDLE: begin
                        if (run && !r_halted && (r_count < CW'(DEPTH))) begin
                            r_state    <= REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_fetch_pc + ADDR_WIDTH'(r_byte_idx);
                        end
                    end
                    REQ: begin
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        if (mem_rvalid) begin
                            if (w_last) begin
                                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(BYTES);
                                r_byte_idx <= '0;
                                r_asm      <= '0;
                                if (w_asm_next == '0) begin
                                    r_halted <= 1'b1;
                                    r_state  <= HALT;
                                end else begin
                                    r_state  <= IDLE;
                                end
                            end else begin
                                r_asm      <= w_asm_next;
                                r_byte_idx <= r_byte_idx + IDXW'(1);
                                r_state    <= REQ;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= r_fetch_pc + ADDR_WIDTH'(r_byte_idx) + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (mem_rvalid) begin
                            r_state <= IDLE;
                        end
                    end
                    HALT: begin
                        r_state <= HALT;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Instruction FIFO; issue gating in IDLE keeps pushes away from a full queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_wptr] <= w_asm_next;
                r_q_pc[r_wptr]    <= r_fetch_pc;
                r_wptr            <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
